latch_bus_arbiter: RTL
======================

LATCH_BUS_ARBITER -- requirements
Module: latch_bus_arbiter

Interface
REQ-001 Parameter N, default 4: number of requesters, and of am2956-style latches sharing one tristate bus; legal range 2..8.
REQ-002 Parameter HOLD, default 2: cycles each granted latch drives the bus (oe_ low); legal range 1..15.
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 req  input  N  per-requester bus request, level-sensitive, synchronous to clk.
REQ-006 g  output  N  per-latch enable: high = transparent, falling edge = capture.
REQ-007 oe_  output  N  per-latch output enable, active-low.
REQ-008 gnt  output  N  one-hot grant, held high for the whole owned transaction.
REQ-009 done  output  N  one-cycle pulse on the last drive cycle of the owner.
REQ-010 busy  output  1  high whenever state is not IDLE.

Function
REQ-011 States SHALL be IDLE, LOAD, CAPTURE, DRIVE and TURN.
REQ-012 All outputs SHALL be registered, decoded from the next state, so g and oe_ are glitch-free.
REQ-013 IDLE: req == 0 -> stay; otherwise pick owner by round-robin, set gnt, -> LOAD.
REQ-014 Round-robin: search starts at index (last owner + 1) mod N and takes the first set req bit.
REQ-015 LOAD: g[owner]=1 for exactly one cycle, all oe_ high, -> CAPTURE.
REQ-016 CAPTURE: g all 0 (falling edge latches data), oe_ all high, load drive counter with HOLD, -> DRIVE.
REQ-017 DRIVE: oe_[owner]=0 for exactly HOLD cycles; done[owner]=1 on the last of them; then -> TURN.
REQ-018 TURN: all oe_ high for one cycle (bus turnaround); gnt cleared. If any req is set, re-arbitrate per REQ-014 -> LOAD; else -> IDLE.
REQ-019 Back-to-back grant period SHALL be HOLD+3 cycles, measured LOAD to LOAD.
REQ-020 At most one oe_ bit low and at most one g bit high in any cycle; oe_ low and g high never on the same index in the same cycle.
REQ-021 A req deassertion after the grant SHALL NOT abort the transaction; it runs to TURN.
REQ-022 Requests raised during a transaction SHALL wait; the owner's still-asserted req is served only after all other pending requesters.
REQ-023 Simultaneous requests SHALL resolve strictly by REQ-014; no requester waits more than N-1 transactions.

Reset
REQ-024 rst SHALL immediately force IDLE, g=0, oe_=all 1, gnt=0, done=0, busy=0, and the round-robin pointer to 0, so index 0 has first priority.
REQ-025 rst asserted mid-transaction SHALL release the bus at once; no done pulse for the aborted owner.
REQ-026 The first rising clk edge after rst deasserts SHALL evaluate req per REQ-013.

Structure
REQ-027 Package latch_arb_pkg SHALL hold the state enumeration and the constants N_MAX=8 and HOLD_MAX=15.
REQ-028 One sub-module rr_picker (N-bit request vector, pointer -> one-hot pick, valid) SHALL implement REQ-014.
REQ-029 The block SHALL drive external latches only and instantiate none.

Verification
REQ-030 Reset, then req=0001 -> g=0001 for 1 cycle, one CAPTURE cycle, oe_=1110 for 2 cycles, done=0001 on the second, TURN, IDLE.
REQ-031 req=1111 held constantly -> owners 0,1,2,3,0 in order; LOAD-to-LOAD spacing 5 cycles; never two oe_ bits low.
REQ-032 req=0100 pulsed for one cycle only -> full transaction for index 2 completes with done=0100.
REQ-033 rst asserted during DRIVE of owner 1 -> oe_=1111 and gnt=0000 asynchronously, no done; after release with req=0010, index 0 is checked first, then owner 1 is granted.
REQ-034 HOLD=1, N=8, req=10000001 held -> owners alternate 0,7,0; drive window 1 cycle; period 4 cycles.
REQ-035 Checker on every scenario: TURN cycle has oe_ all high between consecutive owners, and the REQ-020 exclusivity rules hold.

Source files
------------

// File: rtl/latch_bus_arbiter_pkg.sv
// Shared constants and state encoding for the latch bus arbiter.
package latch_arb_pkg;

    localparam int N_MAX    = 8;
    localparam int HOLD_MAX = 15;
    localparam int CNT_W    = $clog2(HOLD_MAX + 1);

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE    = 3'd0;
    localparam state_t S_LOAD    = 3'd1;
    localparam state_t S_CAPTURE = 3'd2;
    localparam state_t S_DRIVE   = 3'd3;
    localparam state_t S_TURN    = 3'd4;

endpackage

// File: rtl/latch_bus_arbiter_if.sv
// Request/latch-control bundle between the arbiter and the external latches.
interface latch_bus_arbiter_if #(
    parameter int N = 4
);
    logic [N-1:0] req;
    logic [N-1:0] g;
    logic [N-1:0] oe_;
    logic [N-1:0] gnt;
    logic [N-1:0] done;
    logic         busy;

    modport master (input req, output g, oe_, gnt, done, busy);
    modport slave  (output req, input g, oe_, gnt, done, busy);
endinterface

// File: rtl/latch_bus_arbiter_rr_picker.sv
// Round-robin picker: first set request at or after ptr, wrapping modulo N.
module rr_picker #(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  pick,
    output logic          valid
);
    always_comb begin
        int            idx;
        logic [PW-1:0] sel;
        pick  = '0;
        valid = 1'b0;
        idx   = 0;
        sel   = '0;
        for (int i = 0; i < N; i++) begin
            idx = int'(ptr) + i;
            if (idx >= N) idx = idx - N;
            sel = PW'(idx);
            if (!valid && req[sel]) begin
                pick[sel] = 1'b1;
                valid     = 1'b1;
            end
        end
    end
endmodule

// File: rtl/latch_bus_arbiter.sv
// Arbiter sequencing N transparent latches onto one tristate bus:
// LOAD (g high), CAPTURE (g falls), DRIVE (oe_ low for HOLD cycles), TURN.
module latch_bus_arbiter
    import latch_arb_pkg::*;
#(
    parameter int N    = 4,
    parameter int HOLD = 2
) (
    input  logic                clk,
    input  logic                rst,
    latch_bus_arbiter_if.master bus
);
    localparam int PW = $clog2(N);

    state_t           st, nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [PW-1:0]    ptr, ptr_nxt, ptr_after;
    logic [N-1:0]     own, own_nxt, pick;
    logic             pick_vld;
    logic [N-1:0]     g_q, oe_q, gnt_q, done_q;
    logic             busy_q;

    rr_picker #(.N(N), .PW(PW)) u_pick (
        .req   (bus.req),
        .ptr   (ptr),
        .pick  (pick),
        .valid (pick_vld)
    );

    // Pointer moves past the new owner so its own repeat request is searched last.
    always_comb begin
        ptr_after = ptr;
        for (int i = 0; i < N; i++)
            if (pick[i]) ptr_after = (i == N - 1) ? '0 : PW'(i + 1);
    end

    always_comb begin
        nxt     = st;
        cnt_nxt = cnt;
        own_nxt = own;
        ptr_nxt = ptr;
        case (st)
            S_IDLE, S_TURN: begin
                nxt     = S_IDLE;
                own_nxt = '0;
                if (pick_vld) begin
                    nxt     = S_LOAD;
                    own_nxt = pick;
                    ptr_nxt = ptr_after;
                end
            end
            S_LOAD:    nxt = S_CAPTURE;
            S_CAPTURE: begin
                nxt     = S_DRIVE;
                cnt_nxt = CNT_W'(HOLD);
            end
            S_DRIVE: begin
                if (cnt == CNT_W'(1)) nxt = S_TURN;
                else                  cnt_nxt = cnt - CNT_W'(1);
            end
            default:   nxt = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so latch controls come straight from flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st     <= S_IDLE;
            cnt    <= '0;
            ptr    <= '0;
            own    <= '0;
            g_q    <= '0;
            oe_q   <= '1;
            gnt_q  <= '0;
            done_q <= '0;
            busy_q <= 1'b0;
        end else begin
            st     <= nxt;
            cnt    <= cnt_nxt;
            ptr    <= ptr_nxt;
            own    <= own_nxt;
            g_q    <= (nxt == S_LOAD) ? own_nxt : '0;
            oe_q   <= (nxt == S_DRIVE) ? ~own_nxt : '1;
            gnt_q  <= (nxt == S_LOAD || nxt == S_CAPTURE || nxt == S_DRIVE) ? own_nxt : '0;
            done_q <= (nxt == S_DRIVE && cnt_nxt == CNT_W'(1)) ? own_nxt : '0;
            busy_q <= (nxt != S_IDLE);
        end
    end

    assign bus.g    = g_q;
    assign bus.oe_  = oe_q;
    assign bus.gnt  = gnt_q;
    assign bus.done = done_q;
    assign bus.busy = busy_q;
endmodule
